// File: rtl/pio_pattern_master.sv
// -----------------------------------------------------------------------------
// pio_pattern_master
//
// Avalon-MM initiator that drives an 8-bit output PIO (LED bank) on its own.
// It generates a selectable LED pattern and writes it to slave word offset 0
// once every `interval` cycles. The optional readback check is compiled in
// when the macro PIO_PATTERN_MASTER_READBACK_EN is defined. With readback, each
// accepted write is followed by a read of the same register, and a mismatch
// sets a sticky error flag.
//
// Parameters
//   INTERVAL_W  width of the interval input
//   CNT_W       width of step_count
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   enable                  run while high; a rising edge (re)starts the sequence
//   mode                    0=count up, 1=rotate left, 2=ping-pong one-hot, 3=hold
//   seed                    pattern loaded on start
//   interval                cycles between accepted writes (0 behaves as 1)
//   m_address/m_chipselect/m_write_n/m_read_n/m_writedata
//                           Avalon-MM initiator outputs (all registered)
//   m_readdata              slave read data, valid when the read is accepted
//   m_waitrequest           slave stall
//   busy                    high whenever the FSM is not idle
//   step_count              accepted writes since the last start
//   error                   sticky readback mismatch (0 without the readback build)
// -----------------------------------------------------------------------------
module pio_pattern_master #(
  parameter int INTERVAL_W = 24,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [7:0]            seed,
  input  logic [INTERVAL_W-1:0] interval,
  output logic [1:0]            m_address,
  output logic                  m_chipselect,
  output logic                  m_write_n,
  output logic                  m_read_n,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata,
  input  logic                  m_waitrequest,
  output logic                  busy,
  output logic [CNT_W-1:0]      step_count,
  output logic                  error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    , ST_READ = 2'd3
`endif
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_enable_q;
  logic [7:0]            r_pattern;
  logic [7:0]            w_pattern_nxt;
  logic [2:0]            r_pos;
  logic [2:0]            w_pos_nxt;
  logic                  r_dir;          // 0 = sweeping up, 1 = sweeping down
  logic                  w_dir_nxt;
  logic [INTERVAL_W-1:0] r_timer;
  logic [INTERVAL_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic                  r_cs;
  logic                  w_cs_nxt;
  logic                  r_write_n;
  logic                  w_write_n_nxt;
  logic                  r_busy;
  logic                  w_start;
  logic [INTERVAL_W-1:0] w_interval_m1;
  logic [7:0]            w_adv_pattern;
  logic [2:0]            w_adv_pos;
  logic                  w_adv_dir;
  logic [2:0]            w_step_pos;
  logic                  w_unused_rdata;

`ifdef PIO_PATTERN_MASTER_READBACK_EN
  logic                  r_read_n;
  logic                  w_read_n_nxt;
  logic                  r_error;
  logic                  w_error_nxt;
`endif

  // Rotate an 8-bit pattern left by one place.
  function automatic logic [7:0] f_rotl8(input logic [7:0] value);
    f_rotl8 = {value[6:0], value[7]};
  endfunction

  assign w_start       = enable & ~r_enable_q;
  // Timer reload: the strobe period is max(interval,1), so the reload is one less.
  assign w_interval_m1 = (interval == {INTERVAL_W{1'b0}}) ? {INTERVAL_W{1'b0}}
                                                          : (interval - INTERVAL_W'(1));

  // Next pattern (and ping-pong position) if the sequence advances this cycle.
  always_comb begin
    w_step_pos    = r_dir ? (r_pos - 3'd1) : (r_pos + 3'd1);
    w_adv_pattern = r_pattern;
    w_adv_pos     = r_pos;
    w_adv_dir     = r_dir;
    case (mode)
      2'd0: w_adv_pattern = r_pattern + 8'd1;
      2'd1: w_adv_pattern = f_rotl8(r_pattern);
      2'd2: begin
        w_adv_pattern = 8'd1 << w_step_pos;
        w_adv_pos     = w_step_pos;
        // Turn around at the ends so the endpoints are emitted only once.
        if (w_step_pos == 3'd7) begin
          w_adv_dir = 1'b1;
        end else if (w_step_pos == 3'd0) begin
          w_adv_dir = 1'b0;
        end else begin
          w_adv_dir = r_dir;
        end
      end
      2'd3: w_adv_pattern = r_pattern;
      default: w_adv_pattern = r_pattern;
    endcase
  end

  // Next-state, sequence bookkeeping and next bus strobe values.
  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_pos_nxt     = r_pos;
    w_dir_nxt     = r_dir;
    w_timer_nxt   = r_timer;
    w_count_nxt   = r_count;
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    w_error_nxt   = r_error;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt   = ST_WRITE;
          w_pattern_nxt = seed;
          w_pos_nxt     = 3'd0;
          w_dir_nxt     = 1'b0;
          w_count_nxt   = {CNT_W{1'b0}};
`ifdef PIO_PATTERN_MASTER_READBACK_EN
          w_error_nxt   = 1'b0;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          w_count_nxt = r_count + CNT_W'(1);
          w_timer_nxt = w_interval_m1;
`ifdef PIO_PATTERN_MASTER_READBACK_EN
          w_state_nxt = ST_READ;
`else
          if (!enable) begin
            w_state_nxt = ST_IDLE;
          end else if (w_interval_m1 == {INTERVAL_W{1'b0}}) begin
            // Period of one: issue the next write immediately.
            w_state_nxt   = ST_WRITE;
            w_pattern_nxt = w_adv_pattern;
            w_pos_nxt     = w_adv_pos;
            w_dir_nxt     = w_adv_dir;
          end else begin
            w_state_nxt = ST_WAIT;
          end
`endif
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
`ifdef PIO_PATTERN_MASTER_READBACK_EN
      ST_READ: begin
        // The interval timer keeps running while the readback is in flight.
        if (r_timer != {INTERVAL_W{1'b0}}) begin
          w_timer_nxt = r_timer - INTERVAL_W'(1);
        end else begin
          w_timer_nxt = r_timer;
        end
        if (!m_waitrequest) begin
          if (m_readdata[7:0] != r_pattern) begin
            w_error_nxt = 1'b1;
          end else begin
            w_error_nxt = r_error;
          end
          if (!enable) begin
            w_state_nxt = ST_IDLE;
          end else if (r_timer <= INTERVAL_W'(1)) begin
            w_state_nxt   = ST_WRITE;
            w_pattern_nxt = w_adv_pattern;
            w_pos_nxt     = w_adv_pos;
            w_dir_nxt     = w_adv_dir;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_READ;
        end
      end
`endif
      ST_WAIT: begin
        // Leaving when the timer is at 1 makes the strobe spacing exactly the interval.
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer <= INTERVAL_W'(1)) begin
          w_state_nxt   = ST_WRITE;
          w_pattern_nxt = w_adv_pattern;
          w_pos_nxt     = w_adv_pos;
          w_dir_nxt     = w_adv_dir;
        end else begin
          w_state_nxt = ST_WAIT;
          w_timer_nxt = r_timer - INTERVAL_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cs_nxt      = (w_state_nxt == ST_WRITE);
    w_write_n_nxt = (w_state_nxt != ST_WRITE);
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    w_cs_nxt      = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ);
    w_read_n_nxt  = (w_state_nxt != ST_READ);
`endif
  end

  // State, sequence and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_enable_q <= 1'b0;
      r_pattern  <= 8'd0;
      r_pos      <= 3'd0;
      r_dir      <= 1'b0;
      r_timer    <= {INTERVAL_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_cs       <= 1'b0;
      r_write_n  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_enable_q <= enable;
      r_pattern  <= w_pattern_nxt;
      r_pos      <= w_pos_nxt;
      r_dir      <= w_dir_nxt;
      r_timer    <= w_timer_nxt;
      r_count    <= w_count_nxt;
      r_cs       <= w_cs_nxt;
      r_write_n  <= w_write_n_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef PIO_PATTERN_MASTER_READBACK_EN
  // Readback strobe and sticky mismatch flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_n <= 1'b1;
      r_error  <= 1'b0;
    end else begin
      r_read_n <= w_read_n_nxt;
      r_error  <= w_error_nxt;
    end
  end

  assign m_read_n       = r_read_n;
  assign error          = r_error;
  assign w_unused_rdata = ^m_readdata[31:8];
`else
  assign m_read_n       = 1'b1;
  assign error          = 1'b0;
  assign w_unused_rdata = ^m_readdata;
`endif

  assign m_address    = 2'b00;
  assign m_chipselect = r_cs;
  assign m_write_n    = r_write_n;
  // The pattern only changes when a new write starts, so it doubles as the data register.
  assign m_writedata  = {24'h000000, r_pattern};
  assign busy         = r_busy;
  assign step_count   = r_count;

endmodule

// File: tb/tb_pio_pattern_master.sv
module tb_pio_pattern_master;
  localparam int INTERVAL_W = 24;
  localparam int CNT_W      = 16;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [1:0]            mode;
  logic [7:0]            seed;
  logic [INTERVAL_W-1:0] interval;
  logic [1:0]            m_address;
  logic                  m_chipselect;
  logic                  m_write_n;
  logic                  m_read_n;
  logic [31:0]           m_writedata;
  logic [31:0]           m_readdata;
  logic                  m_waitrequest;
  logic                  busy;
  logic [CNT_W-1:0]      step_count;
  logic                  error;

  int checks   = 0;
  int failures = 0;

  // Observed accepted writes (data and cycle stamp) and bus-rule violations.
  logic [7:0] acc_q[$];
  int         cyc_q[$];
  int         cyc     = 0;
  int         rd_cnt  = 0;
  int         viol    = 0;
  int         rd_base = 0;
  logic       inject  = 1'b0;

  always #5 clk = ~clk;

  pio_pattern_master #(.INTERVAL_W(INTERVAL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .seed(seed),
    .interval(interval), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_read_n(m_read_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .busy(busy),
    .step_count(step_count), .error(error)
  );

  // Slave model: echoes the register, corrupting bit 0 on the third read when asked.
  assign m_readdata = {24'h000000,
                       (inject && (rd_cnt == rd_base + 2)) ? (m_writedata[7:0] ^ 8'h01)
                                                           : m_writedata[7:0]};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n === 1'b1 && m_chipselect === 1'b1 && m_write_n === 1'b0 && m_waitrequest === 1'b0) begin
      acc_q.push_back(m_writedata[7:0]);
      cyc_q.push_back(cyc);
    end
    if (reset_n === 1'b1 && m_chipselect === 1'b1 && m_read_n === 1'b0 && m_waitrequest === 1'b0)
      rd_cnt <= rd_cnt + 1;
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    if ((m_write_n === 1'b0 && m_read_n === 1'b0) || m_address !== 2'b00)
      viol <= viol + 1;
`else
    if ((m_write_n === 1'b0 && m_read_n === 1'b0) || m_address !== 2'b00 || m_read_n !== 1'b1)
      viol <= viol + 1;
`endif
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: i-th written pattern after start, straight from the pattern rules.
  function automatic logic [7:0] model_pat(input logic [1:0] md, input logic [7:0] sd, input int i);
    logic [15:0] dbl;
    int ph;
    case (md)
      2'd0: model_pat = sd + 8'(i);
      2'd1: begin
        dbl = {sd, sd} << (i % 8);
        model_pat = dbl[15:8];
      end
      2'd2: begin
        ph = i % 14;
        if (i == 0) model_pat = sd;
        else model_pat = 8'd1 << ((ph <= 7) ? ph : (14 - ph));
      end
      default: model_pat = sd;
    endcase
  endfunction

  function automatic int model_period(input int iv);
    int p;
    p = (iv < 1) ? 1 : iv;
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    if (p < 2) p = 2;
`endif
    return p;
  endfunction

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk(32'(busy), 32'd0, {tag, "_busy"});
    chk(32'(m_chipselect), 32'd0, {tag, "_cs"});
  endtask

  // Start a sequence, check n writes against the model, then stop.
  task automatic run_seq(input logic [1:0] md, input logic [7:0] sd, input int iv,
                         input int n, input string tag);
    int base, waited, per;
    @(negedge clk);
    mode     = md;
    seed     = sd;
    interval = INTERVAL_W'(iv);
    base     = acc_q.size();
    enable   = 1'b1;
    waited   = 0;
    while (acc_q.size() < base + n && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    chk((acc_q.size() >= base + n) ? 32'd1 : 32'd0, 32'd1, {tag, "_timeout"});
    if (acc_q.size() >= base + n) begin
      chk(32'(step_count), 32'(n), {tag, "_count"});
      per = model_period(iv);
      for (int i = 0; i < n; i++) begin
        chk(32'(acc_q[base + i]), 32'(model_pat(md, sd, i)), {tag, "_data"});
        if (i > 0) chk(32'(cyc_q[base + i] - cyc_q[base + i - 1]), 32'(per), {tag, "_gap"});
      end
    end
    enable = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    int base, waited;
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; seed = 8'h00;
    interval = INTERVAL_W'(1); m_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk(32'(m_chipselect), 32'd0, "rst_cs");
    chk(32'(m_write_n), 32'd1, "rst_write_n");
    chk(32'(m_read_n), 32'd1, "rst_read_n");
    chk(32'(m_address), 32'd0, "rst_addr");
    chk(m_writedata, 32'd0, "rst_wdata");
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(step_count), 32'd0, "rst_count");
    chk(32'(error), 32'd0, "rst_error");
    reset_n = 1'b1;

    // Count up across the wrap with interval 4.
    run_seq(2'd0, 8'hFE, 4, 4, "count");
    // Ping-pong sweep, back-to-back where possible.
    run_seq(2'd2, 8'h01, 1, 16, "pingpong");

    // Rotate with a 3-cycle stall on the first write.
    @(negedge clk);
    mode = 2'd1; seed = 8'h81; interval = INTERVAL_W'(2); m_waitrequest = 1'b1;
    base = acc_q.size();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(32'(m_chipselect), 32'd1, "stall_cs");
      chk(32'(m_write_n), 32'd0, "stall_write_n");
      chk(m_writedata, 32'h81, "stall_wdata");
      chk(32'(step_count), 32'd0, "stall_count");
    end
    m_waitrequest = 1'b0;
    waited = 0;
    while (acc_q.size() < base + 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk(32'(acc_q.size() - base), 32'd2, "stall_accepts");
    if (acc_q.size() >= base + 2) begin
      chk(32'(acc_q[base]), 32'h81, "stall_first");
      chk(32'(acc_q[base + 1]), 32'h03, "stall_second");
    end
    enable = 1'b0;
    wait_idle("stall_stop");

    // Enable dropped while a write is stalled.
    @(negedge clk);
    mode = 2'd0; seed = 8'h20; interval = INTERVAL_W'(3); m_waitrequest = 1'b1;
    base = acc_q.size();
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk(32'(m_chipselect), 32'd1, "drop_held_cs");
    chk(32'(m_write_n), 32'd0, "drop_held_wn");
    @(negedge clk);
    m_waitrequest = 1'b0;
    @(negedge clk);
`ifdef PIO_PATTERN_MASTER_READBACK_EN
    @(negedge clk);
`endif
    chk(32'(busy), 32'd0, "drop_busy");
    chk(32'(m_chipselect), 32'd0, "drop_cs");
    chk(32'(step_count), 32'd1, "drop_count");
    repeat (4) @(negedge clk);
    chk(32'(acc_q.size() - base), 32'd1, "drop_no_more");
    run_seq(2'd0, 8'h10, 2, 2, "restart");

    // Reset while a write is stalled.
    @(negedge clk);
    mode = 2'd3; seed = 8'h5A; m_waitrequest = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk(32'(m_chipselect), 32'd1, "midrst_pre_cs");
    #2 reset_n = 1'b0;
    #1;
    chk(32'(m_chipselect), 32'd0, "midrst_cs");
    chk(32'(m_write_n), 32'd1, "midrst_wn");
    chk(m_writedata, 32'd0, "midrst_wdata");
    chk(32'(busy), 32'd0, "midrst_busy");
    enable = 1'b0; m_waitrequest = 1'b0;
    base = acc_q.size();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk(32'(busy), 32'd0, "midrst_idle");
    chk(32'(acc_q.size() - base), 32'd0, "midrst_no_strobe");

    // Randomized sequences.
    for (int r = 0; r < 6; r++) begin
      logic [1:0] rmd;
      logic [7:0] rsd;
      int         riv;
      rmd = 2'($urandom_range(0, 3));
      rsd = 8'($urandom_range(0, 255));
      riv = int'($urandom_range(0, 5));
      run_seq(rmd, rsd, riv, 6, "rand");
    end

`ifdef PIO_PATTERN_MASTER_READBACK_EN
    // Readback mismatch on the third read.
    @(negedge clk);
    rd_base = rd_cnt; inject = 1'b1;
    mode = 2'd0; seed = 8'h40; interval = INTERVAL_W'(3);
    enable = 1'b1;
    waited = 0;
    while (rd_cnt < rd_base + 2 && waited < 200) begin @(negedge clk); waited++; end
    chk((rd_cnt >= rd_base + 2) ? 32'd1 : 32'd0, 32'd1, "rb_timeout2");
    chk(32'(error), 32'd0, "rb_before");
    waited = 0;
    while (rd_cnt < rd_base + 3 && waited < 200) begin @(negedge clk); waited++; end
    chk((rd_cnt >= rd_base + 3) ? 32'd1 : 32'd0, 32'd1, "rb_timeout3");
    chk(32'(error), 32'd1, "rb_set");
    repeat (4) @(negedge clk);
    chk(32'(error), 32'd1, "rb_sticky");
    inject = 1'b0;
    enable = 1'b0;
    wait_idle("rb_stop");
    chk(32'(error), 32'd1, "rb_idle");
    enable = 1'b1;
    @(negedge clk);
    chk(32'(error), 32'd0, "rb_clear");
    enable = 1'b0;
    wait_idle("rb_end");
`else
    chk(32'(error), 32'd0, "no_rb_error");
    chk(32'(m_read_n), 32'd1, "no_rb_read_n");
`endif

    @(negedge clk);
    chk(32'(viol), 32'd0, "bus_rules");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
